// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline types and default widths used by the framebuffer RAM,
// VGA sync generator and scan-out blocks.
package gfx_pkg;

    localparam int unsigned GFX_ADDR_WIDTH = 8;
    localparam int unsigned GFX_DATA_WIDTH = 32;
    localparam int unsigned GFX_BPP        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

    function automatic int unsigned pixels_per_word(int unsigned data_width, int unsigned bpp);
        return data_width / bpp;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with flush; DEPTH must be a power of two so
// the pointers wrap naturally. rdata shows the head word combinationally.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/frame_fetch.sv
// Framebuffer scan-out: fetches one frame of packed words into a prefetch FIFO and
// unpacks them LSB-pixel-first. Define FRAME_FETCH_UNDERFLOW_EN for the sticky underflow flag.
module frame_fetch
    import gfx_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = GFX_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = GFX_DATA_WIDTH,
    parameter int unsigned BPP         = GFX_BPP,
    parameter int unsigned FRAME_WORDS = 256,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  pixel_tick,
    input  logic                  video_on,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [BPP-1:0]        pixel,
    output logic                  underflow
);

    localparam int unsigned PPW    = pixels_per_word(DATA_WIDTH, BPP);
    localparam int unsigned IDX_W  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int unsigned CNT_W  = $clog2(FRAME_WORDS + 1);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [CNT_W-1:0]       word_cnt;
    logic [DATA_WIDTH-1:0]  fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FCNT_W-1:0]      fifo_level_unused;
    logic [DATA_WIDTH-1:0]  unpack_word;
    logic [PPW-1:0][BPP-1:0] unpack_pix;
    logic [IDX_W-1:0]       idx;
    logic                   unpack_valid;
    logic                   push_c;
    logic                   last_word_c;
    logic                   consume_c;
    logic                   last_pix_c;
    logic                   pop_c;

    assign unpack_pix = unpack_word;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .flush (frame_start),
        .wdata (read_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_level_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (frame_start)                         state_next = ST_FETCH;
        else if (state == ST_FETCH && last_word_c) state_next = ST_DONE;
    end

    // Fetch strobes: push whenever the registered FIFO level leaves room.
    always_comb begin
        push_c      = 1'b0;
        last_word_c = 1'b0;
        if (!frame_start && state == ST_FETCH && !fifo_full) begin
            push_c      = 1'b1;
            last_word_c = (word_cnt == CNT_W'(FRAME_WORDS - 1));
        end
    end

    always_comb begin
        consume_c  = !frame_start && pixel_tick && video_on;
        last_pix_c = (idx == IDX_W'(PPW - 1));
        pop_c      = consume_c && !fifo_empty && (!unpack_valid || last_pix_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_addr <= '0;
            word_cnt  <= '0;
        end else if (frame_start) begin
            read_addr <= '0;
            word_cnt  <= '0;
        end else if (push_c) begin
            read_addr <= read_addr + 1'b1;
            word_cnt  <= word_cnt + 1'b1;
        end
    end

    // Unpack register: the next word is preloaded on the edge that shows the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unpack_word  <= '0;
            unpack_valid <= 1'b0;
            idx          <= '0;
            pixel        <= '0;
        end else if (frame_start) begin
            unpack_valid <= 1'b0;
            idx          <= '0;
            pixel        <= '0;
        end else if (pixel_tick) begin
            if (!video_on) begin
                pixel <= '0;
            end else if (unpack_valid) begin
                pixel <= unpack_pix[idx];
                if (last_pix_c) begin
                    idx <= '0;
                    if (!fifo_empty) unpack_word  <= fifo_rdata;
                    else             unpack_valid <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else if (!fifo_empty) begin
                unpack_word  <= fifo_rdata;
                unpack_valid <= 1'b1;
                pixel        <= fifo_rdata[BPP-1:0];
                idx          <= IDX_W'(1);
            end else begin
                pixel <= '0;
            end
        end
    end

`ifdef FRAME_FETCH_UNDERFLOW_EN
    logic starve_c;

    assign starve_c = consume_c && !unpack_valid && fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           underflow <= 1'b0;
        else if (frame_start) underflow <= 1'b0;
        else if (starve_c)    underflow <= 1'b1;
    end
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_frame_fetch.sv
// Self-checking bench for frame_fetch: directed scenarios plus randomized ticks,
// compared every cycle against a pixel-stream reference model.
module tb_frame_fetch;

    localparam int unsigned PPW         = 8;
    localparam int unsigned BPP         = 4;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned FRAME_WORDS = 256;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        pixel_tick;
    logic        video_on;
    logic [7:0]  read_addr;
    logic [31:0] read_data;
    logic [3:0]  pixel;
    logic        underflow;

    logic [31:0] ram [256];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: words fetched, words taken into the unpacker, pixels displayed.
    int       m_f;
    int       m_l;
    int       m_c;
    bit       m_run;
    bit [3:0] m_pix;
    bit       m_under;

    assign read_data = ram[read_addr];

    frame_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pixel_tick  (pixel_tick),
        .video_on    (video_on),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .pixel       (pixel),
        .underflow   (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [3:0] nib(input int w, input int k);
        return 4'((ram[w] >> (k * BPP)) & 32'hF);
    endfunction

    task automatic model_edge(input bit fs, input bit tk, input bit von);
        int  f0;
        int  l0;
        int  w;
        int  k;
        bit  have;
        bit  push;
        f0 = m_f;
        l0 = m_l;
        if (fs) begin
            m_f = 0; m_l = 0; m_c = 0; m_run = 1'b1; m_pix = 4'd0; m_under = 1'b0;
            return;
        end
        push = m_run && ((f0 - l0) < int'(DEPTH)) && (f0 < int'(FRAME_WORDS));
        if (tk) begin
            if (!von) begin
                m_pix = 4'd0;
            end else begin
                w    = m_c / int'(PPW);
                k    = m_c % int'(PPW);
                have = (l0 > w);
                if (!have && f0 > l0) begin
                    m_l  = l0 + 1;
                    have = 1'b1;
                end
                if (have) begin
                    m_pix = nib(w, k);
                    m_c++;
                    if (k == int'(PPW) - 1 && f0 > l0) m_l = l0 + 1;
                end else begin
                    m_pix   = 4'd0;
                    m_under = 1'b1;
                end
            end
        end
        if (push) m_f = f0 + 1;
    endtask

    task automatic cycle(input bit fs, input bit tk, input bit von);
        logic [31:0] exp_u;
        @(negedge clk);
        frame_start = fs;
        pixel_tick  = tk;
        video_on    = von;
        @(posedge clk);
        model_edge(fs, tk, von);
        #1;
`ifdef FRAME_FETCH_UNDERFLOW_EN
        exp_u = 32'(m_under);
`else
        exp_u = 32'd0;
`endif
        check("read_addr", 32'(read_addr), 32'(m_f % 256));
        check("pixel", 32'(pixel), 32'(m_pix));
        check("underflow", 32'(underflow), exp_u);
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pixel_tick = 1'b0; video_on = 1'b0;
        m_f = 0; m_l = 0; m_c = 0; m_run = 1'b0; m_pix = 4'd0; m_under = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[0] = 32'h7654_3210;
        ram[1] = 32'hFEDC_BA98;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", 32'(read_addr), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_uflow", 32'(underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with no ticks: address stops once the FIFO is full.
        cycle(1'b1, 1'b0, 1'b1);
        check("fill_addr0", 32'(read_addr), 32'd0);
        repeat (6) cycle(1'b0, 1'b0, 1'b1);
        check("fill_hold", 32'(read_addr), 32'd4);
        check("fill_pixel", 32'(pixel), 32'd0);

        // Known words give pixel sequence 0..F.
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 16; j++) begin
            cycle(1'b0, 1'b1, 1'b1);
            check("seq", 32'(pixel), 32'(j));
        end

        // Tick coincident with frame_start is ignored; a tick before the first push starves.
        cycle(1'b1, 1'b1, 1'b1);
        check("fs_tick_pixel", 32'(pixel), 32'd0);
        check("fs_tick_uflow", 32'(underflow), 32'd0);
        cycle(1'b0, 1'b1, 1'b1);
`ifdef FRAME_FETCH_UNDERFLOW_EN
        check("early_uflow", 32'(underflow), 32'd1);
`else
        check("early_uflow_tied", 32'(underflow), 32'd0);
`endif
        check("early_pixel", 32'(pixel), 32'd0);

        // Whole frame at one tick per clock, then drain into DONE.
        cycle(1'b1, 1'b0, 1'b1);
        repeat (2048 + 40) cycle(1'b0, 1'b1, 1'b1);
        check("done_addr", 32'(read_addr), 32'd0);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        check("done_hold", 32'(read_addr), 32'd0);

        // Restart mid-frame at word 100.
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2000 && read_addr != 8'd100; i++) cycle(1'b0, 1'b1, 1'b1);
        check("mid_reach", 32'(read_addr), 32'd100);
        cycle(1'b1, 1'b1, 1'b1);
        check("restart_addr", 32'(read_addr), 32'd0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("restart_pix", 32'(pixel), 32'(nib(0, 0)));

        // Blanking mid-word holds the unpack index.
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        for (int j = 0; j < 10; j++) begin
            cycle(1'b0, 1'b1, 1'b0);
            check("blank_pix", 32'(pixel), 32'd0);
        end
        cycle(1'b0, 1'b1, 1'b1);
        check("resume_pix", 32'(pixel), 32'(nib(0, 3)));

        // Randomized ticks, blanking and occasional restarts.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 600) == 0, ($urandom % 3) != 0, ($urandom % 8) != 0);
        for (int i = 0; i < 800; i++)
            cycle(($urandom % 300) == 0, ($urandom % 5) == 0, ($urandom % 4) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
